// File: rtl/key_event_pkg.sv
// -----------------------------------------------------------------------------
// key_event_pkg
// Shared definitions for the key gesture controller:
//   - state_e : FSM state encoding (IDLE, PRESS1, WAIT2, PRESS2, LONG)
//   - EVT_*   : event codes reported on event_code
// -----------------------------------------------------------------------------
package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_e;

    localparam logic [2:0] EVT_NONE   = 3'd0;
    localparam logic [2:0] EVT_CLICK  = 3'd1;
    localparam logic [2:0] EVT_DOUBLE = 3'd2;
    localparam logic [2:0] EVT_LONG   = 3'd3;
    localparam logic [2:0] EVT_REPEAT = 3'd4;

endpackage

// File: rtl/key_evt_timer.sv
// -----------------------------------------------------------------------------
// key_evt_timer
// Interval counter for the gesture FSM. Counts up while enabled, clears on
// request, and saturates at all-ones instead of wrapping.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : clear the count to zero (has priority over en)
//   en         : advance the count by one this cycle
//   limit      : terminal count to compare against
//   tc         : high while the current count equals limit
// -----------------------------------------------------------------------------
module key_evt_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge value of its inputs regardless of the order
    // in which always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == limit);

endmodule

// File: rtl/key_event_ctrl.sv
// -----------------------------------------------------------------------------
// key_event_ctrl
// Gesture controller downstream of the key debounce filter. Classifies each
// key interaction as click, double click, long press or auto-repeat and
// reports it as a one-cycle event with a held event code.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat events while held in LONG).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   key_flag    : one-cycle pulse marking a debounced edge
//   key_state   : debounced level, 0 = pressed, 1 = released (valid with key_flag)
//   event_valid : one-cycle pulse per classified event
//   event_code  : EVT_* code of the latest event, held between events
//   busy        : high whenever the FSM is away from IDLE
// -----------------------------------------------------------------------------
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int CNT_W    = 26,
    parameter int LONG_CYC = 50_000_000,
    parameter int DBL_CYC  = 15_000_000,
    parameter int RPT_CYC  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       event_valid,
    output logic [2:0] event_code,
    output logic       busy
);

    state_e           state;
    state_e           state_next;
    logic             press;
    logic             release_evt;
    logic             tc;
    logic             tmr_clr;
    logic             tmr_en;
    logic             rpt_wrap;
    logic [CNT_W-1:0] limit;
    logic             fire;
    logic [2:0]       fire_code;

    assign press       = key_flag && !key_state;
    assign release_evt = key_flag &&  key_state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: reset is synchronous, so it is tested inside the clocked branch
    // and rst_n does not appear in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Edges win over a coincident timeout, and edges that
    // make no sense in the current state leave it unchanged.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press) state_next = PRESS1;
            PRESS1:  if (release_evt) state_next = WAIT2;
                     else if (tc)     state_next = LONG;
            WAIT2:   if (press)       state_next = PRESS2;
                     else if (tc)     state_next = IDLE;
            PRESS2:  if (release_evt) state_next = IDLE;
            LONG:    if (release_evt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: which event (if any) the current cycle produces.
    // ------------------------------------------------------------------
    always_comb begin
        fire      = 1'b0;
        fire_code = EVT_NONE;
        rpt_wrap  = 1'b0;
        case (state)
            PRESS1: if (!release_evt && tc) begin
                fire      = 1'b1;
                fire_code = EVT_LONG;
            end
            WAIT2: if (!press && tc) begin
                fire      = 1'b1;
                fire_code = EVT_CLICK;
            end
            PRESS2: if (release_evt) begin
                fire      = 1'b1;
                fire_code = EVT_DOUBLE;
            end
`ifdef KEY_REPEAT_EN
            // A release coinciding with the repeat period ends the hold quietly.
            LONG: if (!release_evt && tc) begin
                fire      = 1'b1;
                fire_code = EVT_REPEAT;
                rpt_wrap  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Timer control: one shared counter, limit chosen by state. PRESS2
    // has no timeout and relies on the counter saturating.
    // ------------------------------------------------------------------
    always_comb begin
        limit = '1;
        case (state)
            PRESS1:  limit = CNT_W'(LONG_CYC - 1);
            WAIT2:   limit = CNT_W'(DBL_CYC - 1);
`ifdef KEY_REPEAT_EN
            LONG:    limit = CNT_W'(RPT_CYC - 1);
`endif
            default: limit = '1;
        endcase
    end

    assign tmr_en  = (state != IDLE);
    assign tmr_clr = (state_next != state) || (state == IDLE) || rpt_wrap;

    key_evt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (limit),
        .tc    (tc)
    );

    // ------------------------------------------------------------------
    // Registered outputs. busy tracks the state being entered so it drops
    // in the same cycle the FSM registers IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            event_valid <= 1'b0;
            event_code  <= EVT_NONE;
            busy        <= 1'b0;
        end else begin
            event_valid <= fire;
            if (fire) begin
                event_code <= fire_code;
            end
            busy <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_event_ctrl
// Directed bench for key_event_ctrl with LONG_CYC=100, DBL_CYC=40, RPT_CYC=20.
// Event times are cycle indices where cyc counts rising edges; a flag driven
// just after edge t is said to occur at t. Honours KEY_REPEAT_EN like the RTL.
// -----------------------------------------------------------------------------
module tb_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_flag;
    logic       key_state;
    logic       event_valid;
    logic [2:0] event_code;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ev_cyc[$];
    int ev_code[$];

    key_event_ctrl #(
        .CNT_W    (26),
        .LONG_CYC (100),
        .DBL_CYC  (40),
        .RPT_CYC  (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .event_valid (event_valid),
        .event_code  (event_code),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every event at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (event_valid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_code.push_back(int'(event_code));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Callers are always 1 time unit after a rising edge.
    task automatic wait_to(input int at);
        while (cyc < at) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_at(input int at, input logic st);
        wait_to(at);
        key_flag  = 1'b1;
        key_state = st;
        @(posedge clk);
        #1;
        key_flag = 1'b0;
    endtask

    task automatic clear_log();
        ev_cyc.delete();
        ev_code.delete();
    endtask

    function automatic int ev_c(input int i);
        return (ev_cyc.size() > i) ? ev_cyc[i] : -1;
    endfunction

    function automatic int ev_k(input int i);
        return (ev_code.size() > i) ? ev_code[i] : -1;
    endfunction

    int p;

    initial begin
        rst_n     = 1'b0;
        key_flag  = 1'b0;
        key_state = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, event_valid}, 32'd0);
        check("reset_code",  {29'd0, event_code},  32'd0);
        check("reset_busy",  {31'd0, busy},        32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- single click ----
        clear_log();
        p = cyc + 2;
        pulse_at(p, 1'b0);
        wait_to(p + 5);
        check("click_busy_high", {31'd0, busy}, 32'd1);
        pulse_at(p + 10, 1'b1);
        wait_to(p + 80);
        check("click_count", ev_cyc.size(), 1);
        check("click_time",  ev_c(0), p + 51);
        check("click_code",  ev_k(0), 1);
        check("click_busy_low", {31'd0, busy}, 32'd0);
        check("click_code_held", {29'd0, event_code}, 32'd1);

        // ---- double click ----
        clear_log();
        p = cyc + 2;
        pulse_at(p, 1'b0);
        pulse_at(p + 5, 1'b1);
        pulse_at(p + 15, 1'b0);
        pulse_at(p + 20, 1'b1);
        wait_to(p + 90);
        check("double_count", ev_cyc.size(), 1);
        check("double_time",  ev_c(0), p + 21);
        check("double_code",  ev_k(0), 2);
        check("double_busy_low", {31'd0, busy}, 32'd0);

        // ---- long press held 150 cycles ----
        clear_log();
        p = cyc + 2;
        pulse_at(p, 1'b0);
        pulse_at(p + 150, 1'b1);
        wait_to(p + 200);
`ifdef KEY_REPEAT_EN
        check("long_count",  ev_cyc.size(), 3);
        check("long_time",   ev_c(0), p + 101);
        check("long_code",   ev_k(0), 3);
        check("rpt1_time",   ev_c(1), p + 121);
        check("rpt1_code",   ev_k(1), 4);
        check("rpt2_time",   ev_c(2), p + 141);
        check("rpt2_code",   ev_k(2), 4);
        check("long_code_held", {29'd0, event_code}, 32'd4);
`else
        check("long_count",  ev_cyc.size(), 1);
        check("long_time",   ev_c(0), p + 101);
        check("long_code",   ev_k(0), 3);
        check("long_code_held", {29'd0, event_code}, 32'd3);
`endif
        check("long_busy_low", {31'd0, busy}, 32'd0);

        // ---- dropped edges: release in IDLE, press in PRESS1 ----
        clear_log();
        p = cyc + 2;
        pulse_at(p, 1'b1);
        wait_to(p + 3);
        check("idle_release_busy", {31'd0, busy}, 32'd0);
        pulse_at(p + 5, 1'b0);
        pulse_at(p + 50, 1'b0);     // must not restart the long-press timer
        pulse_at(p + 115, 1'b1);
        wait_to(p + 160);
        check("drop_count", ev_cyc.size(), 1);
        check("drop_time",  ev_c(0), p + 106);
        check("drop_code",  ev_k(0), 3);

        // ---- reset during PRESS1 ----
        clear_log();
        p = cyc + 2;
        pulse_at(p, 1'b0);
        wait_to(p + 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_mid_valid", {31'd0, event_valid}, 32'd0);
        check("rst_mid_code",  {29'd0, event_code},  32'd0);
        check("rst_mid_busy",  {31'd0, busy},        32'd0);
        pulse_at(p + 10, 1'b1);
        wait_to(p + 80);
        check("rst_mid_events", ev_cyc.size(), 0);
        check("rst_mid_busy_after", {31'd0, busy}, 32'd0);

        // ---- second press exactly on the WAIT2 terminal cycle ----
        clear_log();
        p = cyc + 2;
        pulse_at(p, 1'b0);
        pulse_at(p + 5, 1'b1);
        pulse_at(p + 45, 1'b0);
        pulse_at(p + 50, 1'b1);
        wait_to(p + 110);
        check("edge_dbl_count", ev_cyc.size(), 1);
        check("edge_dbl_time",  ev_c(0), p + 51);
        check("edge_dbl_code",  ev_k(0), 2);
        check("edge_dbl_busy",  {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
